// File: rtl/xdma_req_split_pkg.sv
// Shared types for the host-DMA request splitter and its completion tracker.
package xdma_req_split_pkg;

    localparam int PAGE_BITS_DEF  = 12;
    localparam int PADDR_BITS_DEF = 64;
    localparam int LEN_BITS_DEF   = 28;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } split_state_e;

    // Chunk descriptor layout at the default address/length widths.
    typedef struct packed {
        logic [PADDR_BITS_DEF-1:0] paddr;
        logic [LEN_BITS_DEF-1:0]   len;
        logic                      last;
    } chunk_desc_t;

endpackage

// File: rtl/xdma_cpl_tracker.sv
// In-order FIFO of 1-bit "completion wanted" flags, one per outstanding chunk.
module xdma_cpl_tracker #(
    parameter int DEPTH = 16
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic push,
    input  logic push_data,
    input  logic pop,
    output logic pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop frees a slot in the same cycle.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/xdma_req_split.sv
// Cuts host DMA requests at every 2^PAGE_BITS boundary and folds the per-chunk
// XDMA completions back into one upstream completion per original request.
module xdma_req_split
    import xdma_req_split_pkg::*;
#(
    parameter int PADDR_BITS    = PADDR_BITS_DEF,
    parameter int LEN_BITS      = LEN_BITS_DEF,
    parameter int PAGE_BITS     = PAGE_BITS_DEF,
    parameter int N_OUTSTANDING = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  s_req_valid,
    output logic                  s_req_ready,
    input  logic [PADDR_BITS-1:0] s_req_paddr,
    input  logic [LEN_BITS-1:0]   s_req_len,
    input  logic                  s_req_ctl,
    output logic                  s_done_valid,
    output logic                  m_req_valid,
    input  logic                  m_req_ready,
    output logic [PADDR_BITS-1:0] m_req_paddr,
    output logic [LEN_BITS-1:0]   m_req_len,
    output logic                  m_req_last,
    input  logic                  m_done_valid,
    output logic                  err_sticky
);

    localparam int            CW        = LEN_BITS + 1;
    localparam logic [CW-1:0] PAGE_SIZE = CW'(1) << PAGE_BITS;

    split_state_e          state;
    split_state_e          state_next;
    logic [PADDR_BITS-1:0] cur_addr;
    logic [LEN_BITS-1:0]   rem;
    logic                  cur_ctl;
    logic [CW-1:0]         room;
    logic [CW-1:0]         rem_ext;
    logic [CW-1:0]         chunk;
    logic                  chunk_last;
    logic                  load;
    logic                  accept;
    logic                  trk_full;
    logic                  trk_empty;
    logic                  trk_pop_data;

    // One extra bit so a page-aligned address yields a full page rather than 0.
    always_comb begin
        room       = PAGE_SIZE - CW'(cur_addr[PAGE_BITS-1:0]);
        rem_ext    = {1'b0, rem};
        chunk      = (rem_ext < room) ? rem_ext : room;
        chunk_last = (rem_ext == chunk);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        s_req_ready = 1'b0;
        load        = 1'b0;
        case (state)
            IDLE: begin
                s_req_ready = aresetn;
                if (s_req_valid && aresetn && (s_req_len != '0)) begin
                    state_next = SPLIT;
                end
            end
            SPLIT: begin
                load = (!m_req_valid || m_req_ready) && !trk_full;
                if (load && chunk_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = s_req_valid && s_req_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cur_addr <= '0;
            rem      <= '0;
            cur_ctl  <= 1'b0;
        end else if (accept && (s_req_len != '0)) begin
            cur_addr <= s_req_paddr;
            rem      <= s_req_len;
            cur_ctl  <= s_req_ctl;
        end else if (load) begin
            cur_addr <= cur_addr + PADDR_BITS'(chunk);
            rem      <= rem - LEN_BITS'(chunk);
        end
    end

    // Output register holds while stalled and returns to zero once drained.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_req_valid <= 1'b0;
            m_req_paddr <= '0;
            m_req_len   <= '0;
            m_req_last  <= 1'b0;
        end else if (load) begin
            m_req_valid <= 1'b1;
            m_req_paddr <= cur_addr;
            m_req_len   <= LEN_BITS'(chunk);
            m_req_last  <= chunk_last;
        end else if (m_req_valid && m_req_ready) begin
            m_req_valid <= 1'b0;
            m_req_paddr <= '0;
            m_req_len   <= '0;
            m_req_last  <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            s_done_valid <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            s_done_valid <= m_done_valid && !trk_empty && trk_pop_data;
            if ((accept && (s_req_len == '0)) || (m_done_valid && trk_empty)) begin
                err_sticky <= 1'b1;
            end
        end
    end

    xdma_cpl_tracker #(
        .DEPTH (N_OUTSTANDING)
    ) u_tracker (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (load),
        .push_data (chunk_last && cur_ctl),
        .pop       (m_done_valid),
        .pop_data  (trk_pop_data),
        .full      (trk_full),
        .empty     (trk_empty)
    );

endmodule

// File: tb/tb_xdma_req_split.sv
// Self-checking bench for xdma_req_split: directed vector table, corner sequences
// and a randomized run against a page-splitting reference model.
module tb_xdma_req_split;
    import xdma_req_split_pkg::*;

    localparam int N_OUT = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_req_valid = 1'b0;
    logic        s_req_ready;
    logic [63:0] s_req_paddr = '0;
    logic [27:0] s_req_len = '0;
    logic        s_req_ctl = 1'b0;
    logic        s_done_valid;
    logic        m_req_valid;
    logic        m_req_ready = 1'b0;
    logic [63:0] m_req_paddr;
    logic [27:0] m_req_len;
    logic        m_req_last;
    logic        m_done_valid = 1'b0;
    logic        err_sticky;

    always #5 aclk = ~aclk;

    xdma_req_split #(
        .PADDR_BITS    (64),
        .LEN_BITS      (28),
        .PAGE_BITS     (12),
        .N_OUTSTANDING (N_OUT)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_req_valid  (s_req_valid),
        .s_req_ready  (s_req_ready),
        .s_req_paddr  (s_req_paddr),
        .s_req_len    (s_req_len),
        .s_req_ctl    (s_req_ctl),
        .s_done_valid (s_done_valid),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_paddr  (m_req_paddr),
        .m_req_len    (m_req_len),
        .m_req_last   (m_req_last),
        .m_done_valid (m_done_valid),
        .err_sticky   (err_sticky)
    );

    typedef struct {
        chunk_desc_t d;
        logic        ctl;
    } exp_t;

    typedef struct {
        logic [63:0] paddr;
        logic [27:0] len;
        logic        ctl;
        logic        toggle;
        int          n;
        chunk_desc_t c[3];
        int          sdone;
    } vec_t;

    vec_t        vecs[6];
    exp_t        exp_q[$];
    logic        done_q[$];
    chunk_desc_t got_q[$];
    chunk_desc_t stall_d;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   sdone_cnt = 0;
    int   accept_cyc = -1;
    int   first_valid_cyc = -1;
    int   first_hs_cyc = -1;
    int   last_hs_cyc = -1;
    logic sdone_due = 1'b0;
    logic req_taken = 1'b0;
    logic stall_prev = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic chunk_desc_t mk(input logic [63:0] a, input logic [27:0] l, input logic last);
        chunk_desc_t c;
        c.paddr = a;
        c.len   = l;
        c.last  = last;
        return c;
    endfunction

    // Reference: walk the request page by page with plain arithmetic.
    task automatic model_split(input logic [63:0] a, input logic [27:0] l, input logic c);
        logic [63:0] addr;
        longint      left;
        longint      room;
        longint      ch;
        exp_t        e;
        addr = a;
        left = longint'(l);
        while (left > 0) begin
            room    = 4096 - longint'(addr & 64'hFFF);
            ch      = (left < room) ? left : room;
            e.d     = mk(addr, 28'(ch), left == ch);
            e.ctl   = c;
            exp_q.push_back(e);
            addr    = addr + 64'(ch);
            left    = left - ch;
        end
    endtask

    task automatic sample();
        chunk_desc_t cur;
        exp_t        e;
        @(negedge aclk);
        cyc++;
        cur = mk(m_req_paddr, m_req_len, m_req_last);
        if (aresetn) begin
            check("s_done_timing", 96'(s_done_valid), 96'(sdone_due));
            if (s_done_valid) sdone_cnt++;
            check("tracker_bound", 96'((done_q.size() + int'(m_req_valid)) <= N_OUT), 96'(1));
            if (stall_prev) begin
                check("stall_valid", 96'(m_req_valid), 96'(1));
                check("stall_data", 96'(cur), 96'(stall_d));
            end
            if (m_req_valid && accept_cyc >= 0 && cyc > accept_cyc && first_valid_cyc < 0)
                first_valid_cyc = cyc;
            sdone_due = 1'b0;
            if (m_done_valid && done_q.size() > 0) sdone_due = done_q.pop_front();
            if (m_req_valid && m_req_ready) begin
                got_q.push_back(cur);
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                check("chunk_expected", 96'(exp_q.size() > 0), 96'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("chunk_vs_model", 96'(cur), 96'(e.d));
                    done_q.push_back(e.d.last && e.ctl);
                end else begin
                    done_q.push_back(1'b0);
                end
            end
            stall_prev = m_req_valid && !m_req_ready;
            stall_d    = cur;
            if (s_req_valid && s_req_ready) begin
                req_taken  = 1'b1;
                accept_cyc = cyc;
                if (s_req_len != '0) model_split(s_req_paddr, s_req_len, s_req_ctl);
            end
        end
    endtask

    task automatic tick();
        sample();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        aresetn     = 1'b0;
        s_req_valid = 1'b0;
        m_req_ready = 1'b0;
        m_done_valid = 1'b0;
        tick();
        exp_q.delete();
        done_q.delete();
        got_q.delete();
        sdone_due  = 1'b0;
        stall_prev = 1'b0;
        req_taken  = 1'b0;
        accept_cyc = -1;
        check("rst_s_req_ready", 96'(s_req_ready), 96'(0));
        check("rst_m_req_valid", 96'(m_req_valid), 96'(0));
        check("rst_s_done", 96'(s_done_valid), 96'(0));
        check("rst_err", 96'(err_sticky), 96'(0));
        check("rst_data", 96'(mk(m_req_paddr, m_req_len, m_req_last)), 96'(0));
        tick();
        aresetn = 1'b1;
        #1;
        check("rst_exit_ready", 96'(s_req_ready), 96'(1));
    endtask

    task automatic set_vec(input int i, input logic [63:0] a, input logic [27:0] l, input logic c,
                           input logic tg, input int n, input int sd);
        vecs[i].paddr  = a;
        vecs[i].len    = l;
        vecs[i].ctl    = c;
        vecs[i].toggle = tg;
        vecs[i].n      = n;
        vecs[i].sdone  = sd;
        for (int k = 0; k < 3; k++) vecs[i].c[k] = '0;
    endtask

    task automatic applyStimulus(input int i);
        int guard;
        guard = 0;
        got_q.delete();
        sdone_cnt = 0;
        accept_cyc = -1;
        first_valid_cyc = -1;
        first_hs_cyc = -1;
        last_hs_cyc = -1;
        req_taken = 1'b0;
        s_req_paddr = vecs[i].paddr;
        s_req_len   = vecs[i].len;
        s_req_ctl   = vecs[i].ctl;
        s_req_valid = 1'b1;
        m_req_ready = 1'b1;
        m_done_valid = 1'b0;
        while (got_q.size() < vecs[i].n && guard < 100) begin
            tick();
            guard++;
            if (req_taken) s_req_valid = 1'b0;
            if (vecs[i].toggle) m_req_ready = !m_req_ready;
        end
        check("vec_issue_timeout", 96'(guard < 100), 96'(1));
        s_req_valid = 1'b0;
        m_req_ready = 1'b1;
        guard = 0;
        while (done_q.size() > 0 && guard < 100) begin
            m_done_valid = 1'b1;
            tick();
            guard++;
        end
        m_done_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic checkOutput(input int i);
        check($sformatf("vec%0d_nchunks", i), 96'(got_q.size()), 96'(vecs[i].n));
        for (int k = 0; k < vecs[i].n; k++)
            if (k < got_q.size())
                check($sformatf("vec%0d_chunk%0d", i, k), 96'(got_q[k]), 96'(vecs[i].c[k]));
        check($sformatf("vec%0d_latency", i), 96'(first_valid_cyc - accept_cyc), 96'(2));
        check($sformatf("vec%0d_sdone", i), 96'(sdone_cnt), 96'(vecs[i].sdone));
        if (!vecs[i].toggle && vecs[i].n > 1)
            check($sformatf("vec%0d_throughput", i), 96'(last_hs_cyc - first_hs_cyc), 96'(vecs[i].n - 1));
        check($sformatf("vec%0d_err", i), 96'(err_sticky), 96'(0));
    endtask

    task automatic run_random(input int nreq);
        int issued;
        int guard;
        issued = 0;
        guard  = 0;
        do_reset();
        while ((issued < nreq || s_req_valid || exp_q.size() > 0 || done_q.size() > 0) && guard < 30000) begin
            if (req_taken) begin
                s_req_valid = 1'b0;
                req_taken   = 1'b0;
            end
            if (!s_req_valid && issued < nreq && $urandom_range(0, 3) != 0) begin
                s_req_paddr = {$urandom(), $urandom()};
                if ($urandom_range(0, 7) == 0) s_req_paddr[63:16] = '1;
                s_req_len   = 28'($urandom_range(1, 3 * 4096 + 100));
                s_req_ctl   = 1'($urandom_range(0, 1));
                s_req_valid = 1'b1;
                issued++;
            end
            m_req_ready  = ($urandom_range(0, 3) != 0);
            m_done_valid = (done_q.size() > 0) && ($urandom_range(0, 1) == 1);
            tick();
            guard++;
        end
        m_done_valid = 1'b0;
        m_req_ready  = 1'b0;
        tick();
        tick();
        check("random_timeout", 96'(guard < 30000), 96'(1));
        check("random_err", 96'(err_sticky), 96'(0));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int guard;

        set_vec(0, 64'h1000, 28'h1000, 1'b1, 1'b0, 1, 1);
        vecs[0].c[0] = mk(64'h1000, 28'h1000, 1'b1);
        set_vec(1, 64'h0FF0, 28'h30, 1'b1, 1'b0, 2, 1);
        vecs[1].c[0] = mk(64'h0FF0, 28'h10, 1'b0);
        vecs[1].c[1] = mk(64'h1000, 28'h20, 1'b1);
        set_vec(2, 64'h2800, 28'h2000, 1'b0, 1'b1, 3, 0);
        vecs[2].c[0] = mk(64'h2800, 28'h800, 1'b0);
        vecs[2].c[1] = mk(64'h3000, 28'h1000, 1'b0);
        vecs[2].c[2] = mk(64'h4000, 28'h800, 1'b1);
        set_vec(3, 64'h3000, 28'h2800, 1'b1, 1'b0, 3, 1);
        vecs[3].c[0] = mk(64'h3000, 28'h1000, 1'b0);
        vecs[3].c[1] = mk(64'h4000, 28'h1000, 1'b0);
        vecs[3].c[2] = mk(64'h5000, 28'h800, 1'b1);
        set_vec(4, 64'hFFFF_FFFF_FFFF_FF00, 28'h200, 1'b1, 1'b0, 2, 1);
        vecs[4].c[0] = mk(64'hFFFF_FFFF_FFFF_FF00, 28'h100, 1'b0);
        vecs[4].c[1] = mk(64'h0, 28'h100, 1'b1);
        set_vec(5, 64'h7FFF, 28'h1, 1'b0, 1'b0, 1, 0);
        vecs[5].c[0] = mk(64'h7FFF, 28'h1, 1'b1);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(i);
            checkOutput(i);
        end

        // Tracker full: six pages, no completions, only four chunks may load.
        got_q.delete();
        sdone_cnt = 0;
        req_taken = 1'b0;
        s_req_paddr = 64'h10000;
        s_req_len   = 28'h6000;
        s_req_ctl   = 1'b1;
        s_req_valid = 1'b1;
        m_req_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (req_taken) s_req_valid = 1'b0;
        end
        check("full_chunks", 96'(got_q.size()), 96'(4));
        check("full_stalled", 96'(m_req_valid), 96'(0));
        m_done_valid = 1'b1;
        tick();
        m_done_valid = 1'b0;
        check("full_fifth_not_yet", 96'(m_req_valid), 96'(0));
        tick();
        check("full_fifth_valid", 96'(m_req_valid), 96'(1));
        check("full_fifth_addr", 96'(m_req_paddr), 96'(64'h14000));
        guard = 0;
        while ((got_q.size() < 6 || done_q.size() > 0) && guard < 100) begin
            m_done_valid = (done_q.size() > 0);
            tick();
            guard++;
        end
        m_done_valid = 1'b0;
        tick();
        tick();
        check("full_total_chunks", 96'(got_q.size()), 96'(6));
        check("full_sdone", 96'(sdone_cnt), 96'(1));

        // Zero-length request is swallowed and flagged.
        got_q.delete();
        req_taken = 1'b0;
        s_req_paddr = 64'h1234;
        s_req_len   = 28'h0;
        s_req_ctl   = 1'b1;
        s_req_valid = 1'b1;
        tick();
        s_req_valid = 1'b0;
        check("zero_len_accepted", 96'(req_taken), 96'(1));
        check("zero_len_ready", 96'(s_req_ready), 96'(1));
        for (int k = 0; k < 3; k++) tick();
        check("zero_len_err", 96'(err_sticky), 96'(1));
        check("zero_len_no_chunk", 96'(got_q.size() + int'(m_req_valid)), 96'(0));
        do_reset();

        // Reset after two of three chunks, then a fresh request.
        got_q.delete();
        req_taken = 1'b0;
        s_req_paddr = 64'h5800;
        s_req_len   = 28'h1C00;
        s_req_ctl   = 1'b1;
        s_req_valid = 1'b1;
        m_req_ready = 1'b1;
        guard = 0;
        while (got_q.size() < 2 && guard < 50) begin
            tick();
            guard++;
            if (req_taken) s_req_valid = 1'b0;
        end
        check("midsplit_third_loaded", 96'(m_req_valid), 96'(1));
        do_reset();
        applyStimulus(3);
        checkOutput(3);

        // A completion for a chunk dropped by reset hits the empty tracker.
        sdone_cnt = 0;
        m_done_valid = 1'b1;
        tick();
        m_done_valid = 1'b0;
        tick();
        tick();
        check("stray_done_err", 96'(err_sticky), 96'(1));
        check("stray_done_no_sdone", 96'(sdone_cnt), 96'(0));

        run_random(150);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xdma_req_split.md
# xdma_req_split

Host-DMA request splitter between the per-vFPGA TLB arbitration output and the XDMA engine. It takes arbitrated, physically addressed host read or write requests and cuts each one at every 4 KB (2^PAGE_BITS) boundary, so no downstream descriptor ever crosses a page. It tracks outstanding chunks and returns exactly one upstream completion per original request that asked for one. One instance is used per direction (rd, wr).

## Interface
Parameters:
- PADDR_BITS, 64, physical address width
- LEN_BITS, 28, request length width (bytes)
- PAGE_BITS, 12, split boundary is 2^PAGE_BITS bytes
- N_OUTSTANDING, 16, chunk tracker depth; power of two, ≥ 2

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; synchronous, active-low
- s_req_valid  in  1  upstream request valid
- s_req_ready  out  1  upstream request accepted
- s_req_paddr  in  PADDR_BITS  start physical address
- s_req_len  in  LEN_BITS  length in bytes
- s_req_ctl  in  1  upstream wants a completion for this request
- s_done_valid  out  1  one-cycle completion pulse to upstream
- m_req_valid  out  1  chunk descriptor valid to XDMA
- m_req_ready  in  1  XDMA accepts chunk
- m_req_paddr  out  PADDR_BITS  chunk address
- m_req_len  out  LEN_BITS  chunk length, 1..2^PAGE_BITS
- m_req_last  out  1  final chunk of the original request
- m_done_valid  in  1  XDMA completion, one pulse per accepted chunk, in issue order
- err_sticky  out  1  protocol error flag; cleared only by reset

## Operation
- FSM states:
  - IDLE: s_req_ready=1. On s_req_valid with len≠0, latch paddr, len and ctl into cur_addr, rem and cur_ctl, then go to SPLIT.
  - Zero-length request in IDLE: accepted and dropped. No chunk is issued, no done is produced, err_sticky is set, and the FSM stays in IDLE.
  - SPLIT: s_req_ready=0. Compute chunk = min(rem, 2^PAGE_BITS − cur_addr[PAGE_BITS-1:0]) in LEN_BITS+1 bits; there is no truncation when the page offset is 0.
  - Chunk issue: load the output register (paddr=cur_addr, len=chunk, last=(rem==chunk)) when the output register is empty, or is being drained this cycle, AND the tracker is not full. On load, push tracker bit = last & cur_ctl, then cur_addr += chunk and rem −= chunk.
  - When the last chunk is loaded, return to IDLE.
- Output register:
  - m_req_* stays stable while m_req_valid=1 and m_req_ready=0.
  - It is cleared on handshake unless it is reloaded in the same cycle.
- Tracker: a FIFO of N_OUTSTANDING 1-bit entries, counted with a log2(N_OUTSTANDING)+1-bit occupancy counter.
  - Each m_done_valid pops one entry. A popped 1 produces s_done_valid on the next cycle; a popped 0 produces nothing.
  - m_done_valid while the tracker is empty is ignored and sets err_sticky.
  - Push and pop in the same cycle: allowed when not full, and occupancy is unchanged. When full, a push is blocked even if a pop occurs in the same cycle.
- Address arithmetic wraps modulo 2^PADDR_BITS with no error.

## Timing
- Reset values:
  - s_req_ready=0 during reset, then 1 (IDLE) from the first cycle after reset deasserts.
  - m_req_valid=0, s_done_valid=0, err_sticky=0.
  - m_req_* data=0, tracker empty, FSM=IDLE.
- Request acceptance at cycle T gives the first m_req_valid at T+2: T+1 computes the first chunk, T+2 registers it.
- Throughput: with m_req_ready held high, one chunk per cycle.
- Next-request acceptance: the next upstream request is accepted no earlier than the cycle after the last chunk loads.
- m_done_valid at cycle T gives s_done_valid at T+1, exactly one cycle wide.
- Reset mid-operation drops everything:
  - in-flight chunks, tracker contents and the current request;
  - any completions XDMA returns later for dropped chunks hit the empty-tracker rule and set err_sticky.

## Structure
- The shared package holds:
  - PAGE_BITS default;
  - the split FSM state enum (IDLE, SPLIT);
  - a packed chunk-descriptor struct (paddr, len, last).
- Natural sub-module: xdma_cpl_tracker, the 1-bit FIFO plus occupancy counter with push/pop/full/empty. It can be reused by the card-side CDMA path.

## Test plan
- Aligned single page: paddr=0x1000, len=0x1000, ctl=1 → one chunk (0x1000, 0x1000, last=1). After one m_done, exactly one s_done pulse.
- Unaligned split: paddr=0x0FF0, len=0x30, ctl=1 → chunks (0x0FF0, 0x10, last=0) and (0x1000, 0x20, last=1). Two m_done pulses → one s_done, following the second m_done.
- Multi-page with backpressure: paddr=0x2800, len=0x2000, ctl=0, m_req_ready toggling every cycle → chunks 0x800, 0x1000, 0x800. Data stays stable while stalled, and no s_done is produced.
- Tracker full, N_OUTSTANDING=4: a 6-page request with no m_done → exactly 4 chunks issued, then the block stalls. One m_done → a fifth chunk the following cycle.
- Errors:
  - len=0 → no chunk, err_sticky=1, s_req_ready stays 1.
  - Separately, m_done with an empty tracker → err_sticky=1 and no s_done.
- Reset asserted mid-split (after 2 of 3 chunks) → all outputs take their reset values the next cycle. A fresh request after reset splits correctly.
